dma_rd_arbiter: RTL and testbench
=================================

Name: dma_rd_arbiter

Overview:
Round-robin scheduler that picks which CNET MAC queue the DMA engine reads next. It drives the engine's dma_rd_request_q_vld/dma_rd_request_q offer and holds it stable until the engine launches the read. It then tracks the transfer until the engine returns to idle and enforces a hold-off so stale packet-available bits are not re-granted. It sits between the CNET per-MAC packet-available flags plus the driver MAC-enable register, and the DMA control state machine.

Parameters:
NUM_MACS, 16, number of MAC queues arbitrated (1..16); indices >= NUM_MACS are never granted.
HOLDOFF_CYCLES, 4, idle cycles after a read completes before a new offer (0 = none).
TIMEOUT_CYCLES, 1024, offer timeout length; used only with the optional feature.

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock; asynchronous, active-low
cnet_reprog  in  1  CNET reprogramming; synchronous clear, same effect as reset
pkt_avail  in  16  per-MAC packet waiting in CNET
mac_enable  in  16  driver mask; 0 = MAC excluded from arbitration
dma_in_progress  in  1  DMA engine not idle
dma_rd_request  in  1  one-cycle pulse: engine launched read of the offered MAC
dma_rd_mac  in  4  MAC the engine actually read
dma_rd_request_q_vld  out  1  offer valid
dma_rd_request_q  out  4  offered MAC index
last_grant  out  4  most recently granted MAC
arb_busy  out  1  state != ARB_IDLE
mac_mismatch  out  1  sticky: dma_rd_mac != granted MAC at completion
grant_timeout  out  1  one-cycle pulse: offer withdrawn by timeout (feature only)

Behaviour:
- Reset (async) or cnet_reprog (sync) clears all outputs and state:
  - vld=0, q=0, last_grant=NUM_MACS-1 so MAC 0 is searched first, mac_mismatch=0, grant_timeout=0, arb_busy=0.
  - State goes to ARB_IDLE; holdoff and timeout counters go to 0.
  - cnet_reprog wins over every simultaneous event.
- eligible = pkt_avail & mac_enable & valid-index mask.
- Selection: first set bit of eligible, searching upward from last_grant+1 and wrapping modulo NUM_MACS. last_grant itself is checked last.
- States:
  - ARB_IDLE: if eligible != 0, go to ARB_OFFER and register the selection into q. vld rises the cycle after eligible becomes nonzero (1-cycle latency).
  - ARB_OFFER:
    - vld=1; q held constant for the whole state.
    - On a dma_rd_request pulse: go to ARB_ACTIVE, last_grant<=q, vld=0 next cycle.
    - Withdraw (go to ARB_IDLE, vld=0, last_grant unchanged) only if eligible[q] drops while dma_in_progress=0 and no dma_rd_request is present that cycle. If dma_in_progress=1 (engine busy with a write), the offer is held regardless.
  - ARB_ACTIVE:
    - vld=0; q holds the granted MAC.
    - When dma_in_progress is sampled 0, go to ARB_HOLDOFF and load the holdoff counter with HOLDOFF_CYCLES-1. If HOLDOFF_CYCLES=0, go straight to ARB_IDLE.
    - On that exit cycle, if dma_rd_mac != last_grant, set mac_mismatch. It stays set until reset or cnet_reprog.
    - An engine fatal error keeps dma_in_progress=1, so the arbiter stays here until cnet_reprog or reset.
  - ARB_HOLDOFF: decrement the counter each cycle; at 0 go to ARB_IDLE. eligible is ignored during holdoff.
- Simultaneous dma_rd_request and eligible[q] drop: the request wins.
- A dma_rd_request pulse outside ARB_OFFER is ignored.
- Counters saturate at 0; log2 widths are sized from the parameters.

Optional Feature:
Macro DMA_RD_ARB_TIMEOUT_EN.
- Defined:
  - In ARB_OFFER, count cycles with dma_rd_request=0 and dma_in_progress=0; the counter resets on entry to ARB_OFFER.
  - When the count reaches TIMEOUT_CYCLES: withdraw to ARB_IDLE, set last_grant<=q so the stuck MAC is searched last, and pulse grant_timeout for 1 cycle.
- Undefined: no counter; the offer persists indefinitely; grant_timeout is tied to 0.

Test Plan:
1. Reset: reset_n low with pkt_avail=16'hFFFF -> vld=0, last_grant=4'hF. After release, vld=1 with q=0 one cycle after the first clk.
2. Round-robin: pkt_avail=16'h0111, mac_enable=16'hFFFF, pulse dma_rd_request each offer and drop dma_in_progress 3 cycles later -> grants 0,4,8,0. Each new vld rises exactly HOLDOFF_CYCLES+1 cycles after dma_in_progress falls.
3. Mask and wrap: last_grant=14, pkt_avail=16'h8003, mac_enable=16'h7FFF -> q=0, then q=1; MAC 15 is never offered.
4. Withdraw: offer q=5 with dma_in_progress=0, clear pkt_avail[5] before the request -> vld falls the next cycle and last_grant is unchanged. Repeat with dma_in_progress=1 -> offer held with q=5.
5. Mismatch and reprog: grant q=3, return dma_rd_mac=2 at completion -> mac_mismatch=1. Pulse cnet_reprog in ARB_ACTIVE -> all outputs cleared next cycle, state ARB_IDLE.
6. With DMA_RD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: offer q=2 with no request for 8 cycles -> grant_timeout pulses once, vld=0, last_grant=2, and MAC 3 is offered next if eligible.

Source files
------------

// File: rtl/dma_rd_arbiter.sv
// Round-robin selector of the next CNET MAC queue for the DMA read engine.
// Optional offer timeout is enabled with `define DMA_RD_ARB_TIMEOUT_EN.
module dma_rd_arbiter #(
    parameter int NUM_MACS       = 16,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cnet_reprog,
    input  logic [15:0] pkt_avail,
    input  logic [15:0] mac_enable,
    input  logic        dma_in_progress,
    input  logic        dma_rd_request,
    input  logic [3:0]  dma_rd_mac,
    output logic        dma_rd_request_q_vld,
    output logic [3:0]  dma_rd_request_q,
    output logic [3:0]  last_grant,
    output logic        arb_busy,
    output logic        mac_mismatch,
    output logic        grant_timeout
);

    typedef enum logic [1:0] {ARB_IDLE, ARB_OFFER, ARB_ACTIVE, ARB_HOLDOFF} arb_state_t;

    localparam int          HW         = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [3:0]  LG_RST     = 4'(NUM_MACS - 1);
    localparam logic [15:0] VALID_MASK = 16'((32'h1 << NUM_MACS) - 32'h1);

    arb_state_t      state, state_n;
    logic [3:0]      q_r, q_n;
    logic [3:0]      lg_r, lg_n;
    logic            mm_r, mm_n;
    logic [HW-1:0]   hold_cnt, hold_cnt_n;
    logic [15:0]     eligible;
    logic [3:0]      sel;
    logic            found;
    int              idx;

`ifdef DMA_RD_ARB_TIMEOUT_EN
    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    logic [TW-1:0]   to_cnt, to_cnt_n;
    logic            gto_r, gto_n;
    assign grant_timeout = gto_r;
`else
    assign grant_timeout = 1'b0;
`endif

    assign eligible = pkt_avail & mac_enable & VALID_MASK;

    // Search starts just above the last grant so it is considered last.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_MACS; i++) begin
            idx = int'(lg_r) + i;
            if (idx >= NUM_MACS) idx = idx - NUM_MACS;
            if (!found && eligible[idx[3:0]]) begin
                found = 1'b1;
                sel   = idx[3:0];
            end
        end
    end

    always_comb begin
        state_n    = state;
        q_n        = q_r;
        lg_n       = lg_r;
        mm_n       = mm_r;
        hold_cnt_n = hold_cnt;
`ifdef DMA_RD_ARB_TIMEOUT_EN
        to_cnt_n   = '0;
        gto_n      = 1'b0;
`endif
        case (state)
            ARB_IDLE: begin
                if (found) begin
                    state_n = ARB_OFFER;
                    q_n     = sel;
                end
            end
            ARB_OFFER: begin
`ifdef DMA_RD_ARB_TIMEOUT_EN
                to_cnt_n = to_cnt;
`endif
                if (dma_rd_request) begin
                    state_n = ARB_ACTIVE;
                    lg_n    = q_r;
                end else if (!eligible[q_r] && !dma_in_progress) begin
                    state_n = ARB_IDLE;
                end
`ifdef DMA_RD_ARB_TIMEOUT_EN
                else if (!dma_in_progress) begin
                    if (to_cnt >= TO_LAST) begin
                        state_n = ARB_IDLE;
                        lg_n    = q_r;
                        gto_n   = 1'b1;
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                    end
                end
`endif
            end
            ARB_ACTIVE: begin
                if (!dma_in_progress) begin
                    if (dma_rd_mac != lg_r) mm_n = 1'b1;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_n = ARB_IDLE;
                    end else begin
                        state_n    = ARB_HOLDOFF;
                        hold_cnt_n = HOLD_LOAD;
                    end
                end
            end
            default: begin
                if (hold_cnt == '0) state_n = ARB_IDLE;
                else                hold_cnt_n = hold_cnt - 1'b1;
            end
        endcase

        if (cnet_reprog) begin
            state_n    = ARB_IDLE;
            q_n        = '0;
            lg_n       = LG_RST;
            mm_n       = 1'b0;
            hold_cnt_n = '0;
`ifdef DMA_RD_ARB_TIMEOUT_EN
            to_cnt_n   = '0;
            gto_n      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_IDLE;
            q_r      <= '0;
            lg_r     <= LG_RST;
            mm_r     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            q_r      <= q_n;
            lg_r     <= lg_n;
            mm_r     <= mm_n;
            hold_cnt <= hold_cnt_n;
        end
    end

`ifdef DMA_RD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
            gto_r  <= 1'b0;
        end else begin
            to_cnt <= to_cnt_n;
            gto_r  <= gto_n;
        end
    end
`endif

    assign dma_rd_request_q_vld = (state == ARB_OFFER);
    assign dma_rd_request_q     = q_r;
    assign last_grant           = lg_r;
    assign arb_busy             = (state != ARB_IDLE);
    assign mac_mismatch         = mm_r;

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Scoreboard bench for dma_rd_arbiter: expected grants are queued with the
// stimulus and popped when an offer appears.
module tb_dma_rd_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset_n, cnet_reprog;
    logic [15:0] pkt_avail, mac_enable;
    logic        dip, req;
    logic [3:0]  rd_mac;
    logic        vld, busy, mism, gto;
    logic [3:0]  q, lg;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    dma_rd_arbiter #(.NUM_MACS(16), .HOLDOFF_CYCLES(HOLD), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .cnet_reprog(cnet_reprog),
        .pkt_avail(pkt_avail), .mac_enable(mac_enable),
        .dma_in_progress(dip), .dma_rd_request(req), .dma_rd_mac(rd_mac),
        .dma_rd_request_q_vld(vld), .dma_rd_request_q(q), .last_grant(lg),
        .arb_busy(busy), .mac_mismatch(mism), .grant_timeout(gto)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] pa);
        reset_n = 1'b0; cnet_reprog = 1'b0; req = 1'b0; dip = 1'b0;
        rd_mac = '0; mac_enable = 16'hFFFF; pkt_avail = pa;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_vld(input int bound, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < bound) begin
            tick();
            n++;
            if (vld) begin ok = 1'b1; break; end
        end
    endtask

    // Accept the current offer, keep the engine busy a few cycles, then go idle.
    task automatic serve(input logic [3:0] mac);
        req = 1'b1; dip = 1'b1; rd_mac = mac;
        tick();
        req = 1'b0;
        tick(); tick();
        dip = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cnet_reprog = 1'b0; req = 1'b0; dip = 1'b0; rd_mac = '0;
        pkt_avail = 16'hFFFF; mac_enable = 16'hFFFF;
        tick(); tick();
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", vld); end
        n_cmp++; if (lg !== 4'hF) begin n_bad++; $display("FAIL reset_last_grant got %h want f", lg); end
        n_cmp++; if ({busy, mism, gto} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy, mism, gto}); end
        reset_n = 1'b1;
        exp_q.push_back(0);
        tick();
        n_cmp++; if (vld !== 1'b1 || int'(q) !== exp_q.pop_front()) begin
            n_bad++; $display("FAIL reset_first_offer got vld=%b q=%0d want vld=1 q=0", vld, q);
        end
    endtask

    task automatic test_round_robin();
        int n; bit ok; int e;
        do_reset(16'h0000);
        pkt_avail = 16'h0111;
        exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(0);
        wait_vld(5, n, ok);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (!ok || int'(q) !== e) begin
                n_bad++; $display("FAIL rr_grant%0d got vld=%b q=%0d want %0d", k, vld, q, e);
            end
            serve(q);
            // dip is sampled low on the first edge; the offer follows HOLD+1 edges later
            wait_vld(20, n, ok);
            n_cmp++; if (!ok || n !== HOLD + 2) begin
                n_bad++; $display("FAIL rr_latency%0d got %0d edges want %0d", k, n, HOLD + 2);
            end
        end
        n_cmp++; if (mism !== 1'b0) begin n_bad++; $display("FAIL rr_mismatch got %b want 0", mism); end
    endtask

    task automatic test_mask_wrap();
        int n; bit ok; int e;
        do_reset(16'h4000);
        mac_enable = 16'h7FFF;
        wait_vld(5, n, ok);
        n_cmp++; if (!ok || q !== 4'd14) begin n_bad++; $display("FAIL mask_setup got q=%0d want 14", q); end
        serve(4'd14);
        pkt_avail = 16'h8003;
        n_cmp++; if (lg !== 4'd14) begin n_bad++; $display("FAIL mask_last_grant got %0d want 14", lg); end
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        for (int k = 0; k < 3; k++) begin
            wait_vld(20, n, ok);
            e = exp_q.pop_front();
            n_cmp++; if (!ok || int'(q) !== e) begin
                n_bad++; $display("FAIL mask_grant%0d got vld=%b q=%0d want %0d", k, vld, q, e);
            end
            serve(q);
        end
    endtask

    task automatic test_withdraw();
        int n; bit ok;
        do_reset(16'h0020);
        wait_vld(5, n, ok);
        n_cmp++; if (!ok || q !== 4'd5) begin n_bad++; $display("FAIL wd_offer got q=%0d want 5", q); end
        pkt_avail = 16'h0000;
        tick();
        n_cmp++; if (vld !== 1'b0 || lg !== 4'hF) begin
            n_bad++; $display("FAIL wd_idle got vld=%b lg=%h want vld=0 lg=f", vld, lg);
        end
        pkt_avail = 16'h0020;
        tick();
        dip = 1'b1; pkt_avail = 16'h0000;
        tick(); tick(); tick();
        n_cmp++; if (vld !== 1'b1 || q !== 4'd5) begin
            n_bad++; $display("FAIL wd_hold got vld=%b q=%0d want vld=1 q=5", vld, q);
        end
        dip = 1'b0;
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL wd_release got vld=%b want 0", vld); end
    endtask

    task automatic test_mismatch_reprog();
        int n; bit ok;
        do_reset(16'h0008);
        wait_vld(5, n, ok);
        n_cmp++; if (!ok || q !== 4'd3) begin n_bad++; $display("FAIL mm_offer got q=%0d want 3", q); end
        serve(4'd2);
        tick();
        n_cmp++; if (mism !== 1'b1) begin n_bad++; $display("FAIL mm_set got %b want 1", mism); end
        wait_vld(20, n, ok);
        req = 1'b1; dip = 1'b1; rd_mac = 4'd3;
        tick();
        req = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b1 || lg !== 4'd3 || mism !== 1'b1) begin
            n_bad++; $display("FAIL mm_active got busy=%b lg=%0d mm=%b want 1/3/1", busy, lg, mism);
        end
        cnet_reprog = 1'b1;
        tick();
        cnet_reprog = 1'b0;
        n_cmp++; if ({vld, busy, mism, gto} !== 4'b0000 || q !== 4'd0 || lg !== 4'hF) begin
            n_bad++; $display("FAIL reprog_clear got vld=%b busy=%b mm=%b gto=%b q=%0d lg=%h want all 0, lg=f",
                              vld, busy, mism, gto, q, lg);
        end
        dip = 1'b0;
    endtask

    task automatic test_timeout();
        int n; bit ok;
        do_reset(16'h000C);
        exp_q.push_back(2); exp_q.push_back(3);
        wait_vld(5, n, ok);
        n_cmp++; if (!ok || int'(q) !== exp_q.pop_front()) begin n_bad++; $display("FAIL to_offer got q=%0d want 2", q); end
`ifdef DMA_RD_ARB_TIMEOUT_EN
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (gto) break;
        end
        n_cmp++; if (gto !== 1'b1 || n !== 8) begin n_bad++; $display("FAIL to_pulse got gto=%b after %0d want 1 after 8", gto, n); end
        n_cmp++; if (vld !== 1'b0 || lg !== 4'd2) begin
            n_bad++; $display("FAIL to_withdraw got vld=%b lg=%0d want vld=0 lg=2", vld, lg);
        end
        tick();
        n_cmp++; if (gto !== 1'b0 || vld !== 1'b1 || int'(q) !== exp_q.pop_front()) begin
            n_bad++; $display("FAIL to_next got gto=%b vld=%b q=%0d want 0/1/3", gto, vld, q);
        end
`else
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (vld !== 1'b1 || q !== 4'd2 || gto !== 1'b0) n++;
        end
        void'(exp_q.pop_front());
        n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL to_persist got %0d bad cycles want 0", n); end
`endif
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_mask_wrap();
        test_withdraw();
        test_mismatch_reprog();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
